// File: rtl/pll_seq_pkg.sv
// ============================================================================
// Module   : pll_seq_pkg
// Purpose  : Shared state encoding and register map for the PLL speed sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WR_MODE     = 3'd1,
        ST_WR_K        = 3'd2,
        ST_WR_START    = 3'd3,
        ST_WAIT_UNLOCK = 3'd4,
        ST_WAIT_LOCK   = 3'd5,
        ST_SETTLE      = 3'd6
    } seq_state_t;

    // Reconfiguration register map: mode, start trigger, fractional K.
    localparam logic [5:0] c_ADDR_MODE  = 6'd0;
    localparam logic [5:0] c_ADDR_START = 6'd2;
    localparam logic [5:0] c_ADDR_K     = 6'd7;

    localparam logic [6:0] c_UNLOCK_WINDOW = 7'd64;

endpackage

`default_nettype wire

// File: rtl/pll_seq_avmm_wr.sv
// ============================================================================
// Module   : pll_seq_avmm_wr
// Purpose  : Single Avalon-MM write master; holds the transfer until accepted.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pll_seq_avmm_wr (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [5:0]  i_addr,
    input  logic [31:0] i_data,
    input  logic        i_waitrequest,
    output logic        o_write,
    output logic [5:0]  o_address,
    output logic [31:0] o_writedata,
    output logic        o_complete
);

    logic        r_write;
    logic [5:0]  r_addr;
    logic [31:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write <= 1'b0;
            r_addr  <= 6'd0;
            r_data  <= 32'd0;
        end else if (r_write) begin
            if (!i_waitrequest) begin
                r_write <= 1'b0;
            end
        end else if (i_start) begin
            r_write <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end
    end

    // Combinational so the caller can queue the next write with one idle cycle.
    assign o_complete  = r_write & ~i_waitrequest;
    assign o_write     = r_write;
    assign o_address   = r_addr;
    assign o_writedata = r_data;

endmodule

`default_nettype wire

// File: rtl/pll_speed_sequencer.sv
// ============================================================================
// Module   : pll_speed_sequencer
// Purpose  : Retunes the system PLL between native and 60Hz-adjust speeds.
//            Optional lock wait/timeout enabled by PLL_SEQ_LOCK_WAIT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pll_speed_sequencer
    import pll_seq_pkg::*;
#(
    parameter logic [31:0] K_NATIVE     = 32'd3639383488,
    parameter logic [31:0] K_UNDER      = 32'd3262113561,
    parameter int          STABLE_CYC   = 16,
    parameter logic [23:0] LOCK_TIMEOUT = 24'd5000000,
    parameter logic [15:0] SETTLE_CYC   = 16'd1000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        speed_req,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        mgmt_write,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        busy,
    output logic        core_hold,
    output logic        speed_applied,
    output logic        done,
    output logic        lock_err
);

    localparam int             c_STAB_W     = (STABLE_CYC < 1) ? 1 : $clog2(STABLE_CYC + 1);
    localparam logic [c_STAB_W-1:0] c_STAB_MAX = c_STAB_W'(STABLE_CYC);
    localparam logic [c_STAB_W-1:0] c_STAB_ONE = c_STAB_W'(1);
    localparam logic [23:0]    c_SETTLE_LAST = (SETTLE_CYC == 16'd0) ? 24'd0
                                             : ({8'd0, SETTLE_CYC} - 24'd1);

    logic                r_req_s1;
    logic                r_req_s2;
    logic                r_req_last;
    logic [c_STAB_W-1:0] r_stab_cnt;
    logic                r_req_acc;

    seq_state_t  r_state;
    logic        r_target;
    logic        r_applied;
    logic        r_busy;
    logic        r_done;
    logic        r_start;
    logic [5:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic [23:0] r_cnt;
    logic        w_wr_complete;

    // Request is only trusted once it has held the same value for STABLE_CYC samples.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_req_s1   <= 1'b0;
            r_req_s2   <= 1'b0;
            r_req_last <= 1'b0;
            r_stab_cnt <= '0;
            r_req_acc  <= 1'b0;
        end else begin
            r_req_s1   <= speed_req;
            r_req_s2   <= r_req_s1;
            r_req_last <= r_req_s2;
            if (r_req_s2 != r_req_last) begin
                r_stab_cnt <= c_STAB_ONE;
            end else if (r_stab_cnt != c_STAB_MAX) begin
                r_stab_cnt <= r_stab_cnt + c_STAB_ONE;
            end
            if (r_stab_cnt == c_STAB_MAX) begin
                r_req_acc <= r_req_last;
            end
        end
    end

`ifdef PLL_SEQ_LOCK_WAIT_EN
    localparam logic [23:0] c_UNLOCK_LAST = 24'(c_UNLOCK_WINDOW) - 24'd1;
    localparam logic [23:0] c_LOCK_LAST   = (LOCK_TIMEOUT == 24'd0) ? 24'd0
                                          : (LOCK_TIMEOUT - 24'd1);
    logic r_lock_s1;
    logic r_lock_s2;
    logic r_lock_err;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
        end else begin
            r_lock_s1 <= pll_locked;
            r_lock_s2 <= r_lock_s1;
        end
    end

    assign lock_err = r_lock_err;
`else
    assign lock_err = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_target  <= 1'b0;
            r_applied <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_start   <= 1'b0;
            r_wr_addr <= 6'd0;
            r_wr_data <= 32'd0;
            r_cnt     <= 24'd0;
`ifdef PLL_SEQ_LOCK_WAIT_EN
            r_lock_err <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_req_acc != r_applied) begin
                        r_target  <= r_req_acc;
                        r_busy    <= 1'b1;
                        r_start   <= 1'b1;
                        r_wr_addr <= c_ADDR_MODE;
                        r_wr_data <= 32'd0;
                        r_state   <= ST_WR_MODE;
                    end
                end
                ST_WR_MODE: begin
                    if (w_wr_complete) begin
                        r_start   <= 1'b1;
                        r_wr_addr <= c_ADDR_K;
                        r_wr_data <= r_target ? K_UNDER : K_NATIVE;
                        r_state   <= ST_WR_K;
                    end
                end
                ST_WR_K: begin
                    if (w_wr_complete) begin
                        r_start   <= 1'b1;
                        r_wr_addr <= c_ADDR_START;
                        r_wr_data <= 32'd0;
                        r_state   <= ST_WR_START;
                    end
                end
                ST_WR_START: begin
                    if (w_wr_complete) begin
                        r_cnt <= 24'd0;
`ifdef PLL_SEQ_LOCK_WAIT_EN
                        r_state <= ST_WAIT_UNLOCK;
`else
                        r_state <= ST_SETTLE;
`endif
                    end
                end
`ifdef PLL_SEQ_LOCK_WAIT_EN
                ST_WAIT_UNLOCK: begin
                    if (!r_lock_s2 || (r_cnt >= c_UNLOCK_LAST)) begin
                        r_cnt   <= 24'd0;
                        r_state <= ST_WAIT_LOCK;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_lock_s2) begin
                        r_cnt   <= 24'd0;
                        r_state <= ST_SETTLE;
                    end else if (r_cnt >= c_LOCK_LAST) begin
                        // Timeout still records the new speed: the K word was written.
                        r_lock_err <= 1'b1;
                        r_applied  <= r_target;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
`endif
                ST_SETTLE: begin
                    if (r_cnt >= c_SETTLE_LAST) begin
                        r_applied <= r_target;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    pll_seq_avmm_wr u_avmm_wr (
        .clk           (clk_sys),
        .rst           (reset),
        .i_start       (r_start),
        .i_addr        (r_wr_addr),
        .i_data        (r_wr_data),
        .i_waitrequest (mgmt_waitrequest),
        .o_write       (mgmt_write),
        .o_address     (mgmt_address),
        .o_writedata   (mgmt_writedata),
        .o_complete    (w_wr_complete)
    );

    assign busy          = r_busy;
    assign core_hold     = r_busy;
    assign speed_applied = r_applied;
    assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pll_speed_sequencer.sv
// ============================================================================
// Module   : tb_pll_speed_sequencer
// Purpose  : Scoreboard bench for pll_speed_sequencer (honours PLL_SEQ_LOCK_WAIT_EN).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pll_speed_sequencer;

    localparam logic [31:0] c_K_NATIVE = 32'd3639383488;
    localparam logic [31:0] c_K_UNDER  = 32'd3262113561;
`ifdef PLL_SEQ_LOCK_WAIT_EN
    localparam bit c_LOCK_EN = 1'b1;
`else
    localparam bit c_LOCK_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        speed_req = 1'b0;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b1;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        busy;
    logic        core_hold;
    logic        speed_applied;
    logic        done;
    logic        lock_err;

    pll_speed_sequencer #(
        .K_NATIVE     (c_K_NATIVE),
        .K_UNDER      (c_K_UNDER),
        .STABLE_CYC   (16),
        .LOCK_TIMEOUT (24'd300),
        .SETTLE_CYC   (16'd40)
    ) dut (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .speed_req        (speed_req),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked),
        .mgmt_write       (mgmt_write),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .busy             (busy),
        .core_hold        (core_hold),
        .speed_applied    (speed_applied),
        .done             (done),
        .lock_err         (lock_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef enum int {EV_WRITE, EV_DONE, EV_LOCKERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        bit          first;
        logic [5:0]  addr;
        logic [31:0] data;
        bit          mode;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   m_mode = 1'b0;
    bit   lock_stuck = 1'b0;
    int   wr_mode = 0;
    bit   hold_k = 1'b0;
    int   hold_left = 0;
    int   since_start = 1000;
    bit   busy_seen = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every mode change is mode, K, start writes then a completion event.
    function automatic void push_seq(input bit tgt);
        exp_t e;
        e = '{kind: EV_WRITE, first: 1'b1, addr: 6'd0, data: 32'd0, mode: tgt};
        q.push_back(e);
        e = '{kind: EV_WRITE, first: 1'b0, addr: 6'd7, data: (tgt ? c_K_UNDER : c_K_NATIVE), mode: tgt};
        q.push_back(e);
        e = '{kind: EV_WRITE, first: 1'b0, addr: 6'd2, data: 32'd0, mode: tgt};
        q.push_back(e);
        e = '{kind: ((c_LOCK_EN && lock_stuck) ? EV_LOCKERR : EV_DONE), first: 1'b0,
              addr: 6'd0, data: 32'd0, mode: tgt};
        q.push_back(e);
        m_mode = tgt;
    endfunction

    // PLL model: drops lock shortly after the start write, relocks later.
    initial forever begin
        @(posedge clk_sys); #1;
        pll_locked = lock_stuck ? 1'b0 : !(since_start >= 3 && since_start < 20);
    end

    initial forever begin
        @(posedge clk_sys); #1;
        if (hold_k && mgmt_write && mgmt_address == 6'd7 && hold_left > 0) begin
            mgmt_waitrequest = 1'b1;
            hold_left--;
        end else begin
            case (wr_mode)
                0:       mgmt_waitrequest = 1'b0;
                1:       mgmt_waitrequest = ($urandom_range(0, 3) == 0);
                default: mgmt_waitrequest = 1'b1;
            endcase
        end
    end

    bit          p_wr, p_wq, p_cmp, pp_cmp, p_lerr;
    logic [5:0]  p_addr;
    logic [31:0] p_data;

    always @(negedge clk_sys) begin
        exp_t e;
        bit   cmp;
        if (reset) begin
            p_wr = 0; p_wq = 0; p_cmp = 0; pp_cmp = 0; p_lerr = 0;
            p_addr = '0; p_data = '0;
        end else begin
            cmp = mgmt_write && !mgmt_waitrequest;
            if (since_start < 1000) since_start++;
            check(core_hold == busy, "core_hold_eq_busy", core_hold, busy);
            if (busy) busy_seen = 1'b1;
            if (p_wr && p_wq) begin
                check(mgmt_write, "hold_write", mgmt_write, 1);
                check(mgmt_address == p_addr, "hold_addr", mgmt_address, p_addr);
                check(mgmt_writedata == p_data, "hold_data", mgmt_writedata, p_data);
            end
            if (p_cmp) check(!mgmt_write, "idle_gap", mgmt_write, 0);
            if (pp_cmp && q.size() > 0 && q[0].kind == EV_WRITE && !q[0].first)
                check(mgmt_write, "one_idle_only", mgmt_write, 1);
            if (cmp) begin
                if (q.size() == 0 || q[0].kind != EV_WRITE) begin
                    check(1'b0, "unexpected_write", mgmt_address, 0);
                end else begin
                    e = q.pop_front();
                    check(mgmt_address == e.addr, "write_addr", mgmt_address, e.addr);
                    check(mgmt_writedata == e.data, "write_data", mgmt_writedata, e.data);
                    if (e.addr == 6'd2) since_start = 0;
                end
            end
            if (done) begin
                if (q.size() == 0 || q[0].kind != EV_DONE) begin
                    check(1'b0, "unexpected_done", done, 0);
                end else begin
                    e = q.pop_front();
                    check(speed_applied == e.mode, "done_applied", speed_applied, e.mode);
                    check(!busy, "done_busy_low", busy, 0);
                end
            end
            if (lock_err && !p_lerr) begin
                if (q.size() == 0 || q[0].kind != EV_LOCKERR) begin
                    check(1'b0, "unexpected_lock_err", lock_err, 0);
                end else begin
                    e = q.pop_front();
                    check(speed_applied == e.mode, "lockerr_applied", speed_applied, e.mode);
                    check(!core_hold, "lockerr_core_hold", core_hold, 0);
                    check(!done, "lockerr_no_done", done, 0);
                end
            end
            pp_cmp = p_cmp; p_cmp = cmp;
            p_wr = mgmt_write; p_wq = mgmt_waitrequest;
            p_addr = mgmt_address; p_data = mgmt_writedata;
            p_lerr = lock_err;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk_sys); #1; end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin @(negedge clk_sys); t++; end
        while (!(q.size() == 0 && !busy) && t < 4000);
        check(q.size() == 0 && !busy, name, q.size(), 0);
        @(posedge clk_sys); #1;
    endtask

    task automatic request(input bit tgt);
        speed_req = tgt;
        if (tgt != m_mode) push_seq(tgt);
        wait_cycles(30);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(!mgmt_write, {tag, "_write"}, mgmt_write, 0);
        check(mgmt_address == 6'd0, {tag, "_addr"}, mgmt_address, 0);
        check(mgmt_writedata == 32'd0, {tag, "_data"}, mgmt_writedata, 0);
        check(!busy, {tag, "_busy"}, busy, 0);
        check(!core_hold, {tag, "_core_hold"}, core_hold, 0);
        check(!done, {tag, "_done"}, done, 0);
        check(!lock_err, {tag, "_lock_err"}, lock_err, 0);
        check(!speed_applied, {tag, "_applied"}, speed_applied, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit tgt;
        wait_cycles(4);
        @(negedge clk_sys);
        check_reset_outputs("reset_state");
        @(posedge clk_sys); #1;
        reset = 1'b0;

        // Short request pulse must be filtered out.
        busy_seen = 1'b0;
        speed_req = 1'b1;
        wait_cycles(8);
        speed_req = 1'b0;
        wait_cycles(40);
        check(!busy_seen, "glitch_no_busy", busy_seen, 0);

        // Native -> underclock with clean handshake.
        request(1'b1);
        wait_idle("seq_to_under_idle");
        check(speed_applied == 1'b1, "under_applied", speed_applied, 1);

        // Waitrequest stall on the K write.
        hold_k = 1'b1;
        hold_left = 5;
        request(1'b0);
        wait_idle("seq_hold_k_idle");
        check(hold_left == 0, "hold_k_used", hold_left, 0);
        hold_k = 1'b0;

        // Request flips during the tail of a sequence: back-to-back retune.
        speed_req = 1'b1;
        push_seq(1'b1);
        t = 0;
        while (q.size() > 0 && q[0].kind == EV_WRITE && t < 500) begin
            @(posedge clk_sys); #1;
            t++;
        end
        check(t < 500, "b2b_writes_seen", t, 500);
        wait_cycles(5);
        request(1'b0);
        wait_idle("seq_b2b_idle");
        check(speed_applied == 1'b0, "b2b_applied", speed_applied, 0);

        // Lock never returns.
        lock_stuck = 1'b1;
        request(1'b1);
        wait_idle("seq_lock_stuck_idle");
        lock_stuck = 1'b0;
        check(lock_err == c_LOCK_EN, "lock_err_final", lock_err, c_LOCK_EN);
        check(speed_applied == 1'b1, "lock_stuck_applied", speed_applied, 1);

        // Reset in the middle of a stalled write.
        wr_mode = 2;
        speed_req = 1'b0;
        t = 0;
        while (!mgmt_write && t < 200) begin
            @(posedge clk_sys); #1;
            t++;
        end
        check(mgmt_write, "reset_test_write_seen", mgmt_write, 1);
        wait_cycles(2);
        reset = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check_reset_outputs("mid_write_reset");
        q.delete();
        m_mode = 1'b0;
        wr_mode = 0;
        @(posedge clk_sys); #1;
        reset = 1'b0;

        request(1'b1);
        wait_idle("post_reset_seq_idle");
        check(speed_applied == 1'b1, "post_reset_applied", speed_applied, 1);

        for (int i = 0; i < 8; i++) begin
            wr_mode = $urandom_range(0, 1);
            speed_req = !m_mode;
            wait_cycles($urandom_range(1, 8));
            tgt = 1'($urandom_range(0, 1));
            request(tgt);
            wait_idle("rand_seq_idle");
            check(speed_applied == m_mode, "rand_applied", speed_applied, m_mode);
        end

        check(q.size() == 0, "queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pll_speed_sequencer.md
PLL_SPEED_SEQUENCER -- requirements
Module: pll_speed_sequencer

Interface
REQ-001 SHALL have parameter K_NATIVE, default 32'd3639383488: fractional-divider word for native speed.
REQ-002 SHALL have parameter K_UNDER, default 32'd3262113561: fractional-divider word for 60Hz-adjust speed.
REQ-003 SHALL have parameter STABLE_CYC, default 16: cycles the synchronised request must hold before acceptance.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 24'd5000000: maximum cycles to wait for PLL lock.
REQ-005 SHALL have parameter SETTLE_CYC, default 16'd1000: post-retune settle cycles.
REQ-006 SHALL have port clk_sys, input, 1: sole clock, the PLL management clock.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port speed_req, input, 1: requested mode (0 native, 1 underclock); asynchronous to clk_sys.
REQ-009 SHALL have port mgmt_waitrequest, input, 1: Avalon-MM waitrequest from the reconfig block.
REQ-010 SHALL have port pll_locked, input, 1: PLL lock indicator; asynchronous.
REQ-011 SHALL have port mgmt_write, output, 1: Avalon-MM write strobe.
REQ-012 SHALL have port mgmt_address, output, 6: register address.
REQ-013 SHALL have port mgmt_writedata, output, 32: register data.
REQ-014 SHALL have port busy, output, 1: high from sequence start until return to IDLE.
REQ-015 SHALL have port core_hold, output, 1: request to stall the game core while the PLL is retuning.
REQ-016 SHALL have port speed_applied, output, 1: mode currently programmed.
REQ-017 SHALL have port done, output, 1: one-cycle pulse on successful completion.
REQ-018 SHALL have port lock_err, output, 1: sticky lock-timeout flag.

Function
REQ-019 SHALL pass speed_req and pll_locked through 2-flop synchronisers; speed_req is accepted only after STABLE_CYC consecutive equal synchronised samples.
REQ-020 SHALL start a sequence from IDLE when the accepted request differs from speed_applied, and SHALL raise busy and core_hold in the cycle after acceptance.
REQ-021 SHALL implement the states IDLE -> WR_MODE (addr 0, data 0) -> WR_K (addr 7, data K_UNDER if the target is 1, else K_NATIVE) -> WR_START (addr 2, data 0) -> WAIT_UNLOCK -> WAIT_LOCK -> SETTLE -> IDLE.
REQ-022 SHALL hold mgmt_write, mgmt_address and mgmt_writedata stable while mgmt_waitrequest=1; a write completes on the first cycle with mgmt_write=1 and mgmt_waitrequest=0.
REQ-023 SHALL leave exactly one idle cycle (mgmt_write=0) between completed writes.
REQ-024 SHALL latch the target mode at sequence start; request changes during a sequence SHALL be ignored until IDLE, then re-evaluated (back-to-back retune permitted).
REQ-025 WAIT_UNLOCK SHALL advance on synchronised lock=0 or after 64 cycles, whichever is first.
REQ-026 WAIT_LOCK SHALL advance on synchronised lock=1; after LOCK_TIMEOUT cycles it SHALL set lock_err, update speed_applied, and go to IDLE without a done pulse.
REQ-027 On SETTLE expiry, the block SHALL update speed_applied, pulse done, and drop busy and core_hold in the same cycle.
REQ-028 All counters SHALL saturate and never wrap.

Reset
REQ-029 Reset SHALL force IDLE, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, core_hold=0, done=0, lock_err=0 and speed_applied=0 (the PLL powers up native), and SHALL clear the synchronisers and counters.
REQ-030 Reset mid-write SHALL abort the transfer immediately; after reset, a stable request of 1 SHALL trigger a full sequence.

Configuration
REQ-031 Macro PLL_SEQ_LOCK_WAIT_EN defined: WAIT_UNLOCK/WAIT_LOCK are present and lock_err is functional.
REQ-032 Macro PLL_SEQ_LOCK_WAIT_EN undefined: WR_START goes directly to SETTLE, pll_locked is ignored, and lock_err is tied to 0.

Structure
REQ-033 Package pll_seq_pkg SHALL hold the state enum, the address constants (0, 2, 7) and the unlock-window constant 64.
REQ-034 Sub-module pll_seq_avmm_wr SHALL implement the single Avalon-MM write handshake (start/addr/data in, complete pulse out).

Verification
REQ-035 Reset, then hold speed_req=1, waitrequest=0, locked toggles 1->0->1: three writes (0/0, 7/3262113561, 2/0), then done, speed_applied=1.
REQ-036 Hold waitrequest=1 for 5 cycles during WR_K: address=7 and data stay stable, write stays high, and exactly one transfer completes.
REQ-037 Pulse speed_req high for 8 cycles (shorter than STABLE_CYC): no write occurs and busy stays 0.
REQ-038 Toggle speed_req 1->0 during SETTLE: first sequence finishes, then a second sequence writes K=3639383488 and speed_applied returns to 0.
REQ-039 Hold locked=0 for the whole sequence: lock_err=1 after LOCK_TIMEOUT, no done pulse, core_hold=0.
REQ-040 Assert reset during WR_MODE with waitrequest=1: mgmt_write=0 on the next cycle and all outputs at their reset values.
